ccip_tx_flow_batcher: RTL and testbench

Per-flow batching write-back engine for the CPU-NIC TX path: accepts RPC lines tagged with a flow ID, buffers them in per-flow FIFOs and writes them to host memory over CCI-P channel 1 as multi-line eREQ_WRLINE_I batches. It adds three behaviours to the existing transmitter:
- honours sRx_c1TxAlmFull backpressure;
- flushes partial batches after a configurable timeout;
- scans flows round-robin after every batch.

---
 rtl/ccip_tx_flow_batcher.sv | 235 +++++++++++++++++++++++
 tb/tb_ccip_tx_flow_batcher.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_tx_flow_batcher.sv
// Per-flow batching CCI-P channel-1 write-back engine for the CPU-NIC TX path.
// Lines are buffered per flow and drained round-robin as batches or timed-out partial flushes.
package ccip_if_pkg;
   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;
   typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
   typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
   typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                             eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;
   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;
   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;
endpackage

module ccip_tx_flow_fifo #(
   parameter int DATA_WIDTH  = 512,
   parameter int LFIFO_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [LFIFO_DEPTH:0]  count
);
   localparam int DEPTH = 2**LFIFO_DEPTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [LFIFO_DEPTH:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{LFIFO_DEPTH{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{LFIFO_DEPTH{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // A push into a full FIFO is only issued alongside a pop; the slot is read before it is overwritten.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[LFIFO_DEPTH-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr_q[LFIFO_DEPTH-1:0]];
   assign count = wr_ptr_q - rd_ptr_q;
endmodule

module ccip_tx_flow_batcher
   import ccip_if_pkg::*;
#(
   parameter int NIC_ID            = 0,
   parameter int LMAX_NUM_OF_FLOWS = 2,
   parameter int DATA_WIDTH        = 512,
   parameter int LFIFO_DEPTH       = 3,
   parameter int TIMEOUT_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
   input  t_ccip_clAddr                 tx_base_addr,
   input  logic [1:0]                   l_tx_batch_size,
   input  logic [TIMEOUT_WIDTH-1:0]     flush_timeout,
   input  logic [DATA_WIDTH-1:0]        rpc_in,
   input  logic                         rpc_in_valid,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
   input  logic                         sRx_c1TxAlmFull,
   output t_if_ccip_c1_Tx               sTx_c1,
   output logic                         ccip_tx_ready,
   output logic                         pdrop_out,
   output logic [31:0]                  drop_cnt_out,
   output logic                         error
);
   localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
   localparam int CW        = LFIFO_DEPTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_BATCH, S_FLUSH} t_state;

   t_state                                   state_q, state_d;
   logic [LMAX_NUM_OF_FLOWS-1:0]             ptr_q, ptr_d, next_ptr;
   logic [1:0]                               l_q, l_d, l_eff;
   logic [2:0]                               n_q, n_d, i_q, i_d, b_eff;
   logic [MAX_FLOWS-1:0][CW-1:0]             count;
   logic [MAX_FLOWS-1:0][DATA_WIDTH-1:0]     dout;
   logic [MAX_FLOWS-1:0][TIMEOUT_WIDTH-1:0]  age_q, age_d;
   logic [MAX_FLOWS-1:0]                     push_vec, pop_vec;
   logic                                     pop, accept, id_ok, push_ok, drop;
   logic [CW-1:0]                            cnt_ptr;
   logic [TIMEOUT_WIDTH-1:0]                 age_ptr;
   t_if_ccip_c1_Tx                           tx_q, tx_d;
   logic                                     pdrop_q, pdrop_d, error_q, error_d;
   logic [31:0]                              drop_cnt_q, drop_cnt_d;
   logic [31:0]                              unused_nic_id;

   assign unused_nic_id = 32'(NIC_ID);

   always_comb begin
      accept     = start && rpc_in_valid;
      id_ok      = rpc_flow_id_in <= number_of_flows;
      push_ok    = accept && id_ok &&
                   ((count[rpc_flow_id_in] != CW'(2**LFIFO_DEPTH)) || (pop && ptr_q == rpc_flow_id_in));
      drop       = accept && !push_ok;
      pdrop_d    = drop;
      drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 32'd1 : drop_cnt_q;
      error_d    = error_q || (accept && !id_ok);
      push_vec   = '0;
      pop_vec    = '0;
      push_vec[rpc_flow_id_in] = push_ok;
      pop_vec[ptr_q]           = pop;
      for (int f = 0; f < MAX_FLOWS; f++) begin
         if (count[f] == '0 || pop_vec[f])  age_d[f] = '0;
         else if (age_q[f] != '1)           age_d[f] = age_q[f] + TIMEOUT_WIDTH'(1);
         else                               age_d[f] = age_q[f];
      end
   end

   for (genvar f = 0; f < MAX_FLOWS; f++) begin : g_flow
      ccip_tx_flow_fifo #(.DATA_WIDTH(DATA_WIDTH), .LFIFO_DEPTH(LFIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push_vec[f]),
         .pop   (pop_vec[f]),
         .din   (rpc_in),
         .dout  (dout[f]),
         .count (count[f])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         l_q        <= '0;
         n_q        <= '0;
         i_q        <= '0;
         age_q      <= '0;
         tx_q       <= '0;
         pdrop_q    <= 1'b0;
         drop_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         l_q        <= l_d;
         n_q        <= n_d;
         i_q        <= i_d;
         age_q      <= age_d;
         tx_q       <= tx_d;
         pdrop_q    <= pdrop_d;
         drop_cnt_q <= drop_cnt_d;
         error_q    <= error_d;
      end
   end

   // Almost-full is only consulted at the decision point; a started burst always runs to completion.
   always_comb begin
      l_eff    = (l_tx_batch_size == 2'd3) ? 2'd2 : l_tx_batch_size;
      b_eff    = 3'd1 << l_eff;
      cnt_ptr  = count[ptr_q];
      age_ptr  = age_q[ptr_q];
      next_ptr = (ptr_q >= number_of_flows) ? '0 : ptr_q + LMAX_NUM_OF_FLOWS'(1);
      state_d  = state_q;
      ptr_d    = ptr_q;
      l_d      = l_q;
      n_d      = n_q;
      i_d      = i_q;
      case (state_q)
         S_IDLE: begin
            i_d = '0;
            if (32'(cnt_ptr) >= 32'(b_eff) && !sRx_c1TxAlmFull) begin
               state_d = S_BATCH;
               l_d     = l_eff;
               n_d     = b_eff;
            end else if (flush_timeout != '0 && age_ptr >= flush_timeout && cnt_ptr != '0 &&
                         !sRx_c1TxAlmFull) begin
               state_d = S_FLUSH;
               l_d     = l_eff;
               n_d     = (32'(cnt_ptr) >= 32'(b_eff - 3'd1)) ? b_eff - 3'd1 : 3'(cnt_ptr);
            end else begin
               ptr_d = next_ptr;
            end
         end
         default: begin
            i_d = i_q + 3'd1;
            if (i_q == n_q - 3'd1) begin
               state_d = S_IDLE;
               ptr_d   = next_ptr;
            end
         end
      endcase
   end

   always_comb begin
      pop  = (state_q != S_IDLE);
      tx_d = '0;
      if (pop) begin
         tx_d.valid           = 1'b1;
         tx_d.hdr.req_type    = eREQ_WRLINE_I;
         tx_d.hdr.vc_sel      = eVC_VH0;
         tx_d.hdr.sop         = (state_q == S_FLUSH) || (i_q == 3'd0);
         tx_d.hdr.cl_len      = (state_q == S_FLUSH || l_q == 2'd0) ? eCL_LEN_1 :
                                (l_q == 2'd1) ? eCL_LEN_2 : eCL_LEN_4;
         tx_d.hdr.address     = tx_base_addr + (t_ccip_clAddr'(ptr_q) << l_q) + t_ccip_clAddr'(i_q);
         tx_d.data            = t_ccip_clData'(dout[ptr_q]);
      end
   end

   assign sTx_c1        = tx_q;
   assign ccip_tx_ready = ~sRx_c1TxAlmFull;
   assign pdrop_out     = pdrop_q;
   assign drop_cnt_out  = drop_cnt_q;
   assign error         = error_q;
endmodule

// File: tb/tb_ccip_tx_flow_batcher.sv
// Scoreboard bench for ccip_tx_flow_batcher: stimulus queues expected beats, a negedge monitor checks them.
module tb_ccip_tx_flow_batcher;
   import ccip_if_pkg::*;

   localparam logic [41:0] BASE = 42'h1000;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [1:0]     number_of_flows;
   t_ccip_clAddr   tx_base_addr;
   logic [1:0]     l_tx_batch_size;
   logic [15:0]    flush_timeout;
   logic [511:0]   rpc_in;
   logic           rpc_in_valid;
   logic [1:0]     rpc_flow_id_in;
   logic           sRx_c1TxAlmFull;
   t_if_ccip_c1_Tx sTx_c1;
   logic           ccip_tx_ready;
   logic           pdrop_out;
   logic [31:0]    drop_cnt_out;
   logic           error;

   ccip_tx_flow_batcher dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .number_of_flows (number_of_flows),
      .tx_base_addr    (tx_base_addr),
      .l_tx_batch_size (l_tx_batch_size),
      .flush_timeout   (flush_timeout),
      .rpc_in          (rpc_in),
      .rpc_in_valid    (rpc_in_valid),
      .rpc_flow_id_in  (rpc_flow_id_in),
      .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
      .sTx_c1          (sTx_c1),
      .ccip_tx_ready   (ccip_tx_ready),
      .pdrop_out       (pdrop_out),
      .drop_cnt_out    (drop_cnt_out),
      .error           (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      int                 cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0, fails = 0, cyc = 0, beats = 0, pdrops = 0, t0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pdrop_out) pdrops++;
      if (sTx_c1.valid) begin
         beats++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got addr=%0h at cycle %0d, required no beat", sTx_c1.hdr.address, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (sTx_c1.hdr !== mon_e.hdr || sTx_c1.data !== mon_e.data) begin
               fails++;
               $display("FAIL beat: got addr=%0h len=%0d sop=%0b hdr=%0h data=%0h, required addr=%0h len=%0d sop=%0b hdr=%0h data=%0h",
                        sTx_c1.hdr.address, sTx_c1.hdr.cl_len, sTx_c1.hdr.sop, sTx_c1.hdr, sTx_c1.data[31:0],
                        mon_e.hdr.address, mon_e.hdr.cl_len, mon_e.hdr.sop, mon_e.hdr, mon_e.data[31:0]);
            end
            if (mon_e.cyc != 0) begin
               tests++;
               if (cyc != mon_e.cyc) begin
                  fails++;
                  $display("FAIL beat_cycle: got cycle %0d, required %0d", cyc, mon_e.cyc);
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) cycles(1);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycles(3);
      reset = 1'b0;
      t0 = cyc;
   endtask

   task automatic push(input logic [1:0] f, input logic [511:0] d);
      rpc_flow_id_in = f;
      rpc_in         = d;
      rpc_in_valid   = 1'b1;
      cycles(1);
      rpc_in_valid   = 1'b0;
   endtask

   task automatic expect_beat(input logic [41:0] addr, input t_ccip_clLen len, input logic sop,
                              input logic [511:0] d, input int ecyc);
      exp_t e;
      e.hdr          = '0;
      e.hdr.req_type = eREQ_WRLINE_I;
      e.hdr.vc_sel   = eVC_VH0;
      e.hdr.cl_len   = len;
      e.hdr.sop      = sop;
      e.hdr.address  = addr;
      e.data         = d;
      e.cyc          = ecyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         cycles(1);
         n++;
      end
      chk("drain_pending_beats", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, p0;
      start = 1'b1; rpc_in_valid = 1'b0; rpc_in = '0; rpc_flow_id_in = '0;
      number_of_flows = 2'd3; tx_base_addr = BASE; l_tx_batch_size = 2'd2;
      flush_timeout = '0; sRx_c1TxAlmFull = 1'b0;
      do_reset();
      chk("reset_valid", 128'(sTx_c1.valid), 128'(0));
      chk("reset_hdr", 128'(sTx_c1.hdr), 128'(0));
      chk("reset_pdrop", 128'(pdrop_out), 128'(0));
      chk("reset_drop_cnt", 128'(drop_cnt_out), 128'(0));
      chk("reset_error", 128'(error), 128'(0));
      chk("ready_released", 128'(ccip_tx_ready), 128'(1));
      sRx_c1TxAlmFull = 1'b1; #1;
      chk("ready_almfull", 128'(ccip_tx_ready), 128'(0));
      sRx_c1TxAlmFull = 1'b0;

      // batch of 4 on flow 1
      do_reset();
      for (int i = 0; i < 4; i++) expect_beat(BASE + 42'(4 + i), eCL_LEN_4, i == 0, 512'(32'hA0 + i), t0 + 7 + i);
      for (int i = 0; i < 4; i++) push(2'd1, 512'(32'hA0 + i));
      wait_drain(50);
      cycles(5);

      // round robin, B=1, flows 0 and 2
      l_tx_batch_size = 2'd0; sRx_c1TxAlmFull = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++)
         expect_beat(BASE + ((k % 2 == 0) ? 42'd0 : 42'd2), eCL_LEN_1, 1'b1,
                     512'(((k % 2 == 0) ? 32'h100 : 32'h200) + k / 2), t0 + 10 + 3 * k);
      for (int k = 0; k < 6; k++) push((k % 2 == 0) ? 2'd0 : 2'd2, 512'(((k % 2 == 0) ? 32'h100 : 32'h200) + k / 2));
      cycles(2);
      sRx_c1TxAlmFull = 1'b0;
      wait_drain(100);
      cycles(5);

      // partial flush after timeout
      l_tx_batch_size = 2'd1; flush_timeout = 16'd10;
      do_reset();
      expect_beat(BASE + 42'd6, eCL_LEN_1, 1'b1, 512'(32'hF3), t0 + 13);
      push(2'd3, 512'(32'hF3));
      wait_drain(60);
      flush_timeout = 16'd0;
      do_reset();
      b0 = beats;
      push(2'd3, 512'(32'hF4));
      cycles(40);
      chk("no_flush_when_disabled", 128'(beats - b0), 128'(0));

      // backpressure held, released, re-raised mid-batch
      l_tx_batch_size = 2'd2; sRx_c1TxAlmFull = 1'b1;
      do_reset();
      b0 = beats;
      for (int i = 0; i < 4; i++) expect_beat(BASE + 42'(i), eCL_LEN_4, i == 0, 512'(32'h300 + i), t0 + 22 + i);
      for (int f = 1; f < 4; f++)
         for (int i = 0; i < 4; i++)
            expect_beat(BASE + 42'(4 * f + i), eCL_LEN_4, i == 0, 512'(32'h300 + 16 * f + i), t0 + 31 + 5 * (f - 1) + i);
      for (int f = 0; f < 4; f++)
         for (int i = 0; i < 4; i++) push(2'(f), 512'(32'h300 + 16 * f + i));
      wait_until(t0 + 20);
      chk("no_beats_while_almfull", 128'(beats - b0), 128'(0));
      sRx_c1TxAlmFull = 1'b0;
      wait_until(t0 + 23);
      sRx_c1TxAlmFull = 1'b1;
      wait_until(t0 + 29);
      sRx_c1TxAlmFull = 1'b0;
      wait_drain(100);
      cycles(5);

      // overflow with l=3 treated as 4-line batches
      l_tx_batch_size = 2'd3; sRx_c1TxAlmFull = 1'b1;
      do_reset();
      p0 = pdrops;
      for (int i = 0; i < 10; i++) push(2'd0, 512'(32'h500 + i));
      cycles(2);
      chk("overflow_pdrop_pulses", 128'(pdrops - p0), 128'(2));
      chk("overflow_drop_cnt", 128'(drop_cnt_out), 128'(2));
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) expect_beat(BASE + 42'(i), eCL_LEN_4, i == 0, 512'(32'h500 + 4 * k + i), 0);
      sRx_c1TxAlmFull = 1'b0;
      wait_drain(100);
      cycles(5);

      // bad flow id, then reset mid-batch
      number_of_flows = 2'd1; l_tx_batch_size = 2'd2;
      do_reset();
      push(2'd3, 512'(32'h666));
      chk("bad_id_error", 128'(error), 128'(1));
      chk("bad_id_drop_cnt", 128'(drop_cnt_out), 128'(1));
      for (int i = 0; i < 2; i++) expect_beat(BASE + 42'(i), eCL_LEN_4, i == 0, 512'(32'h400 + i), t0 + 8 + i);
      for (int i = 0; i < 4; i++) push(2'd0, 512'(32'h400 + i));
      wait_until(t0 + 9);
      reset = 1'b1;
      cycles(1);
      chk("mid_batch_reset_valid", 128'(sTx_c1.valid), 128'(0));
      chk("mid_batch_reset_error", 128'(error), 128'(0));
      chk("mid_batch_reset_drop_cnt", 128'(drop_cnt_out), 128'(0));
      reset = 1'b0;
      b0 = beats;
      cycles(20);
      chk("no_beats_after_abort", 128'(beats - b0), 128'(0));
      wait_drain(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
